// File: rtl/mmio_uart_tx_pkg.sv
// Shared I/O window definitions: base address, register offsets, TX FSM
// state codes, request struct and the STATUS word packer.
package mmio_uart_tx_pkg;

   localparam logic [15:0] IO_BASE       = 16'h2000;
   localparam logic [15:0] IO_DATA_OFS   = 16'h0000;
   localparam logic [15:0] IO_STATUS_OFS = 16'h0001;

   // TX FSM state codes (2-bit, kept as plain constants for older decoders)
   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   // Decoded CPU access for this peripheral
   typedef struct packed {
      logic       wr;
      logic       rd;
      logic       is_data;
      logic       is_status;
      logic [7:0] wdata;
   } io_req_t;

   // STATUS layout: {8'h00, overflow, count[4:0], full, busy}
   function automatic logic [15:0] pack_status(input logic       ovf,
                                               input logic [4:0] cnt,
                                               input logic       full,
                                               input logic       busy);
      return {8'h00, ovf, cnt, full, busy};
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART shifter. A push while full is
// accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage array; no reset needed, occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, STATUS register with
// sticky overflow, TX FIFO, and the start/data/stop serialiser.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR    = IO_BASE,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] IO_Addr,
   input  logic [15:0] IO_Data_In,
   input  logic        IO_Wr_En,
   input  logic        IO_Rd_En,
   output logic [15:0] IO_Data_Out,
   output logic        IO_Hit,
   output logic        Uart_Tx,
   output logic        Tx_Irq
);

   localparam int          AW          = $clog2(FIFO_DEPTH);
   localparam int          CW          = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [15:0] DATA_ADDR   = BASE_ADDR + IO_DATA_OFS;
   localparam logic [15:0] STATUS_ADDR = BASE_ADDR + IO_STATUS_OFS;

   io_req_t       req;
   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          overflow;
   logic          busy, bit_done;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [AW:0]   fifo_count;
   logic [7:0]    unused_hi;

   // Upper write-data byte has no meaning for this device
   assign unused_hi = IO_Data_In[15:8];

   // Decode the forwarded CPU access into a request
   always_comb begin
      req           = '0;
      req.wr        = IO_Wr_En;
      req.rd        = IO_Rd_En;
      req.is_data   = (IO_Addr == DATA_ADDR);
      req.is_status = (IO_Addr == STATUS_ADDR);
      req.wdata     = IO_Data_In[7:0];
   end

   assign busy      = (state != TX_IDLE);
   assign bit_done  = (baud_cnt == BAUD_LAST);
   assign fifo_pop  = (state == TX_IDLE) && !fifo_empty;
   assign fifo_push = req.wr && req.is_data;
   assign Tx_Irq    = fifo_empty && !busy;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (req.wdata),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow: a dropped byte sets it, a STATUS read clears it, set wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end else if (req.rd && req.is_status) begin
         overflow <= 1'b0;
      end
   end

   // Registered read port; DATA reads return zero, data out holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         IO_Data_Out <= '0;
         IO_Hit      <= 1'b0;
      end else begin
         IO_Hit <= req.rd && (req.is_data || req.is_status);
         if (req.rd && req.is_status)
            IO_Data_Out <= pack_status(overflow, 5'(fifo_count), fifo_full, busy);
         else if (req.rd && req.is_data)
            IO_Data_Out <= '0;
      end
   end

   // Serialiser: line is registered and changes on entry to each state/bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         Uart_Tx  <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               baud_cnt <= '0;
               Uart_Tx  <= 1'b1;
               if (fifo_pop) begin
                  shift   <= fifo_dout;
                  bit_idx <= '0;
                  state   <= TX_START;
                  Uart_Tx <= 1'b0;
               end
            end
            TX_START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  state    <= TX_DATA;
                  Uart_Tx  <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            TX_DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= TX_STOP;
                     Uart_Tx <= 1'b1;
                  end else begin
                     shift   <= {1'b0, shift[7:1]};
                     Uart_Tx <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  state    <= TX_IDLE;
                  Uart_Tx  <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-position reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mmio_uart_tx;

   localparam int          C      = 4;
   localparam int          DEPTH  = 4;
   localparam logic [15:0] A_DATA = 16'h2000;
   localparam logic [15:0] A_STAT = 16'h2001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] io_addr = '0, io_din = '0;
   logic        io_wr = 1'b0, io_rd = 1'b0;
   logic [15:0] io_dout;
   logic        io_hit, uart_tx, tx_irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE_ADDR    (A_DATA),
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .IO_Addr     (io_addr),
      .IO_Data_In  (io_din),
      .IO_Wr_En    (io_wr),
      .IO_Rd_En    (io_rd),
      .IO_Data_Out (io_dout),
      .IO_Hit      (io_hit),
      .Uart_Tx     (uart_tx),
      .Tx_Irq      (tx_irq)
   );

   // ---------------- reference model ----------------
   // Queue of pending bytes, byte on the wire, and position within the
   // 10*C-cycle frame (-1 when nothing is being sent).
   bit [7:0]  m_q[$];
   bit [7:0]  m_cur;
   int        m_fpos = -1;
   bit        m_ovf;
   bit [15:0] m_dout;
   bit        m_hit;

   function automatic logic exp_tx();
      int b;
      if (m_fpos < 0) return 1'b1;
      b = m_fpos / C;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_fpos = -1;
         m_ovf  = 1'b0;
         m_dout = '0;
         m_hit  = 1'b0;
         m_cur  = '0;
      end else begin
         bit pop, full, wdat, rstat, rdat;
         pop   = (m_fpos < 0) && (m_q.size() > 0);
         full  = (m_q.size() == DEPTH);
         wdat  = io_wr && (io_addr == A_DATA);
         rstat = io_rd && (io_addr == A_STAT);
         rdat  = io_rd && (io_addr == A_DATA);
         m_hit = rstat || rdat;
         if (rstat) m_dout = {8'h00, m_ovf, 5'(m_q.size()), full, (m_fpos >= 0)};
         else if (rdat) m_dout = '0;
         if (wdat && full && !pop) m_ovf = 1'b1;
         else if (rstat) m_ovf = 1'b0;
         if (m_fpos >= 0) begin
            m_fpos++;
            if (m_fpos == 10*C) m_fpos = -1;
         end
         if (pop) begin
            m_cur  = m_q.pop_front();
            m_fpos = 0;
         end
         if (wdat && (!full || pop)) m_q.push_back(io_din[7:0]);
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("dout", io_dout, m_dout);
      chk("hit",  16'(io_hit),  16'(m_hit));
      chk("tx",   16'(uart_tx), 16'(exp_tx()));
      chk("irq",  16'(tx_irq),  16'((m_fpos < 0) && (m_q.size() == 0)));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic wr, input logic rd);
      io_addr = a; io_din = d; io_wr = wr; io_rd = rd;
      cyc();
      io_wr = 1'b0; io_rd = 1'b0;
   endtask

   task automatic wait_low(input string nm);
      int n = 0;
      while (uart_tx !== 1'b0 && n < 200) begin cyc(); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for start bit actual none required fall", nm);
      end
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (tx_irq !== 1'b1 && n < 600) begin cyc(); n++; end
      if (n >= 600) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for idle actual busy required idle", nm);
      end
   endtask

   initial begin
      logic [9:0] frame55;
      int k, lows;
      frame55 = 10'b10_1010_1010;   // start 0, 0x55 LSB first, stop 1

      // reset state
      cyc(3);
      chk("rst_dout", io_dout, 16'h0000);
      chk("rst_hit",  16'(io_hit),  16'h0);
      chk("rst_tx",   16'(uart_tx), 16'h1);
      chk("rst_irq",  16'(tx_irq),  16'h1);
      rst_n = 1'b1;
      cyc(2);

      // 1: single 0x55 frame, bit-by-bit at mid-bit
      bus(A_DATA, 16'h0055, 1, 0);
      wait_low("t1");
      cyc(C/2);
      for (int i = 0; i < 10; i++) begin
         chk("t1_bit", 16'(uart_tx), 16'(frame55[i]));
         chk("t1_irq_busy", 16'(tx_irq), 16'h0);
         cyc(C);
      end
      chk("t1_irq_done", 16'(tx_irq), 16'h1);

      // 2: six writes while idle -> one in shifter, four queued, sixth dropped
      wait_idle("t2a");
      for (int i = 0; i < 6; i++) bus(A_DATA, 16'(8'hA0 + i), 1, 0);
      bus(A_STAT, 16'h0, 0, 1);
      chk("t2_stat", io_dout, 16'h0093);
      chk("t2_hit", 16'(io_hit), 16'h1);
      bus(A_STAT, 16'h0, 0, 1);
      chk("t2_stat2", io_dout, 16'h0013);
      wait_idle("t2b");

      // 3: write coinciding with the pop while full is accepted
      bus(A_DATA, 16'h0011, 1, 0);
      for (int i = 0; i < 4; i++) bus(A_DATA, 16'(8'h21 + i), 1, 0);
      k = 0;
      while (!(m_fpos < 0 && m_q.size() == DEPTH) && k < 200) begin cyc(); k++; end
      chk("t3_reach_pop", 16'(k < 200), 16'h1);
      bus(A_DATA, 16'h0077, 1, 0);
      bus(A_STAT, 16'h0, 0, 1);
      chk("t3_stat", io_dout, 16'h0013);
      wait_idle("t3");

      // 4: asynchronous reset in the middle of a data bit
      bus(A_DATA, 16'h0000, 1, 0);
      bus(A_DATA, 16'h00AA, 1, 0);
      bus(A_DATA, 16'h00BB, 1, 0);
      cyc(2*C);
      chk("t4_pre_tx", 16'(uart_tx), 16'h0);
      #2 rst_n = 1'b0;
      #1 chk("t4_async_tx", 16'(uart_tx), 16'h1);
      cyc(2);
      rst_n = 1'b1;
      bus(A_STAT, 16'h0, 0, 1);
      chk("t4_stat", io_dout, 16'h0000);
      lows = 0;
      for (int i = 0; i < 60; i++) begin if (uart_tx !== 1'b1) lows++; cyc(); end
      chk("t4_no_residual", 16'(lows), 16'h0);

      // 5: undecoded addresses are ignored
      bus(16'h2002, 16'h0077, 1, 0);
      bus(16'h1FFF, 16'h0066, 1, 0);
      bus(16'h2002, 16'h0000, 0, 1);
      chk("t5_hit", 16'(io_hit), 16'h0);
      bus(A_STAT, 16'h0, 0, 1);
      chk("t5_stat", io_dout, 16'h0000);
      cyc(3);
      chk("t5_tx", 16'(uart_tx), 16'h1);

      // 6: back-to-back frames separated by exactly one idle cycle
      bus(A_DATA, 16'h0000, 1, 0);
      bus(A_DATA, 16'h0000, 1, 0);
      wait_low("t6");
      cyc(9*C);
      k = 0;
      while (uart_tx !== 1'b0 && k < 50) begin cyc(); k++; end
      chk("t6_period", 16'(9*C + k), 16'd41);
      wait_idle("t6");

      // random traffic, with one reset pulse part-way
      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 3))
            0: io_addr = A_DATA;
            1: io_addr = A_STAT;
            2: io_addr = 16'h2002;
            default: io_addr = 16'h1FFF;
         endcase
         io_din = 16'($urandom);
         io_wr  = ($urandom_range(0, 99) < 12);
         io_rd  = ($urandom_range(0, 99) < 20);
         if (i == 1200) begin
            io_wr = 1'b0; io_rd = 1'b0;
            #2 rst_n = 1'b0;
            cyc(2);
            rst_n = 1'b1;
         end else begin
            cyc();
         end
      end
      io_wr = 1'b0; io_rd = 1'b0;
      wait_idle("rand");
      cyc(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
